// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// control encodings, FSM states and the captured request payload.
package dmem_responder_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned F3_W_SZ = 3;
  localparam int unsigned CNT_W   = 4;

  // funct3 access size / sign codes
  localparam logic [F3_W_SZ-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_SZ-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_SZ-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_SZ-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_SZ-1:0] F3_HU = 3'b101;

  // Same encodings the control decoder drives on memread/memwrite
  localparam logic DO_MEM_READ  = 1'b1;
  localparam logic DO_MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                memread;
    logic                memwrite;
    logic [F3_W_SZ-1:0]  funct3;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
  } dmem_req_t;

  // Unsigned sizes exist only for loads
  function automatic logic f3_legal(input logic [F3_W_SZ-1:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and data replication,
// load lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [F3_W_SZ-1:0] funct3_i,
  input  logic [1:0]         lane_i,
  input  logic [XLEN-1:0]    wdata_i,
  input  logic [XLEN-1:0]    rword_i,
  output logic [3:0]         be_o,
  output logic [XLEN-1:0]    wrep_o,
  output logic [XLEN-1:0]    rdata_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be_o    = 4'b0000;
    wrep_o  = wdata_i;
    rdata_o = '0;
    shifted = rword_i >> {lane_i, 3'b000};
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << lane_i;
        wrep_o  = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        be_o    = 4'b0001 << lane_i;
        wrep_o  = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      F3_H: begin
        be_o    = 4'b0011 << lane_i;
        wrep_o  = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_HU: begin
        be_o    = 4'b0011 << lane_i;
        wrep_o  = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, shifted[15:0]};
      end
      F3_W: begin
        be_o    = 4'b1111;
        wrep_o  = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable latency,
// byte/half/word stores with lane merge, extended loads, error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_memread,
  input  logic                req_memwrite,
  input  logic [F3_W_SZ-1:0]  req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  dmem_req_t         req_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_rdata_q;
  logic              resp_err_q;

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

  logic [31:0]       off_c;
  logic [1:0]        lane_c;
  logic [IDX_W-1:0]  widx_c;
  logic [XLEN-1:0]   rword_c;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wrep_c;
  logic [XLEN-1:0]   load_c;
  logic              is_store_c;
  logic              commit_c;
  logic              mem_we_c;
  logic              err_d;
  logic [XLEN-1:0]   rdata_d;

  // Decode of the captured request; wrap below the base lands out of range
  assign off_c      = req_q.addr - ADDR_BASE;
  assign lane_c     = off_c[1:0];
  assign widx_c     = off_c[IDX_W+1:2];
  assign rword_c    = mem_q[widx_c];
  assign is_store_c = (req_q.memwrite == DO_MEM_WRITE);
  assign commit_c   = (state_q == ST_WAIT) && (cnt_q == '0);

  dmem_lane_align u_align (
    .funct3_i (req_q.funct3),
    .lane_i   (lane_c),
    .wdata_i  (req_q.wdata),
    .rword_i  (rword_c),
    .be_o     (be_c),
    .wrep_o   (wrep_c),
    .rdata_o  (load_c)
  );

  always_comb begin
    err_d = 1'b0;
    if ((req_q.memread == DO_MEM_READ) == (req_q.memwrite == DO_MEM_WRITE)) err_d = 1'b1;
    if (!f3_legal(req_q.funct3, is_store_c)) err_d = 1'b1;
    if ((req_q.funct3 == F3_H || req_q.funct3 == F3_HU) && lane_c[0]) err_d = 1'b1;
    if ((req_q.funct3 == F3_W) && (lane_c != 2'b00)) err_d = 1'b1;
    if (off_c >= SPAN) err_d = 1'b1;
    rdata_d = (err_d || is_store_c) ? '0 : load_c;
  end

  assign mem_we_c = commit_c && !rst && !err_d && is_store_c;

  // Storage array is deliberately left out of reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_c && be_c[i]) begin
        mem_q[widx_c][8*i +: 8] <= wrep_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_q.memread  <= req_memread;
            req_q.memwrite <= req_memwrite;
            req_q.funct3   <= req_funct3;
            req_q.addr     <= req_addr;
            req_q.wdata    <= req_wdata;
            cnt_q          <= CNT_INIT;
            req_ready_q    <= 1'b0;
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err_d;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against a byte-array
// reference model of the memory rules.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_memread = 1'b0;
  logic        req_memwrite = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_BASE(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_memread  (req_memread),
    .req_memwrite (req_memwrite),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mem_m [4*DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access rules in plain arithmetic
  function automatic void ref_access(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rdat, output logic err);
    logic [31:0] off;
    int nb;
    logic sgn;
    logic [31:0] v;
    off = addr - BASE;
    sgn = 1'b0;
    case (f3)
      3'b000: begin nb = 1; sgn = 1'b1; end
      3'b001: begin nb = 2; sgn = 1'b1; end
      3'b010: nb = 4;
      3'b100: nb = 1;
      3'b101: nb = 2;
      default: nb = 0;
    endcase
    err = (rd == wr) || (nb == 0) || (wr && f3[2]) || (off >= 32'(4*DEPTH));
    if (!err && (off % 32'(nb)) != 0) err = 1'b1;
    rdat = '0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) mem_m[off + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[off + 32'(i)];
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rdat = v;
    end
  endfunction

  // One request/response exchange, checking handshake timing on the way
  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output logic [31:0] rdat, output logic err);
    int n;
    @(negedge clk);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_memread = rd; req_memwrite = wr; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(req_ready), 32'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!resp_valid && n < 40);
    check_eq({tag, "_latency"}, 32'(n), 32'(LAT));
    rdat = resp_rdata;
    err  = resp_err;
    if (!resp_valid) return;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check_eq({tag, "_hold_rdata"}, resp_rdata, rdat);
      check_eq({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd, input int hold,
                    output logic [31:0] rdat, output logic err);
    logic [31:0] exp_d;
    logic exp_e;
    ref_access(rd, wr, f3, addr, wd, exp_d, exp_e);
    xfer(tag, rd, wr, f3, addr, wd, hold, rdat, err);
    check_eq({tag, "_rdata"}, rdat, exp_d);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_resp_err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic e;
    logic [31:0] a;
    logic [2:0] f;
    logic rd, wr;
    int sel;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // Preload the test window so every load has a known reference value
    for (int w = 0; w < 64; w++)
      op("init", 1'b0, 1'b1, 3'b010, 32'(4*w), $urandom, 0, r, e);

    op("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, r, e);
    op("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, r, e);
    check_eq("lw10_const", r, 32'hDEAD_BEEF);
    op("sb13", 1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080, 0, r, e);
    op("lb13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 0, r, e);
    check_eq("lb13_const", r, 32'hFFFF_FF80);
    op("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 0, r, e);
    check_eq("lbu13_const", r, 32'h0000_0080);
    op("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, r, e);
    check_eq("lw10b_const", r, 32'h80AD_BEEF);
    op("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_1234, 0, r, e);
    op("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 0, r, e);
    check_eq("lhu12_const", r, 32'h0000_1234);
    op("lh11", 1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 0, r, e);
    check_eq("lh11_err_const", 32'(e), 32'd1);
    op("sw12", 1'b0, 1'b1, 3'b010, 32'h12, 32'hFFFF_FFFF, 0, r, e);
    op("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5, r, e);
    check_eq("lw10c_const", r, 32'h1234_BEEF);

    // Illegal requests, then confirm the touched word is intact
    op("both", 1'b1, 1'b1, 3'b010, 32'h20, 32'h1111_1111, 0, r, e);
    op("none", 1'b0, 1'b0, 3'b010, 32'h20, 32'h2222_2222, 0, r, e);
    op("oor", 1'b0, 1'b1, 3'b010, 32'(4*DEPTH), 32'h3333_3333, 0, r, e);
    op("wrap", 1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 0, r, e);
    op("f3_011", 1'b0, 1'b1, 3'b011, 32'h20, 32'h4444_4444, 0, r, e);
    op("sbu", 1'b0, 1'b1, 3'b100, 32'h20, 32'h5555_5555, 0, r, e);
    op("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, r, e);
    op("lw_last", 1'b1, 1'b0, 3'b010, 32'(4*DEPTH - 4), 32'h0, 0, r, e);

    // Reset one cycle after a store is accepted: store must be discarded
    @(negedge clk);
    req_memread = 1'b0; req_memwrite = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midrst_idle");
    op("lw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, r, e);

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 19));
      rd = 1'b0; wr = 1'b0;
      if (sel == 0) begin rd = 1'b1; wr = 1'b1; end
      else if (sel == 1) begin rd = 1'b0; wr = 1'b0; end
      else if (sel < 10) rd = 1'b1;
      else wr = 1'b1;
      f = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 29));
      if (sel == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 7));
      else if (sel == 1) a = 32'hFFFF_FFFC;
      op("rnd", rd, wr, f, a, $urandom, int'($urandom_range(0, 3)), r, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
